// File: rtl/keypad_scanner.sv
// keypad_scanner: row-strobed 4x4 active-low keypad scanner with frame-level
// debounce. Emits a one-cycle key_valid pulse and key_code for each accepted
// single-key press, and key_held until the matrix is seen fully released.
module keypad_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row_out,
    input  logic [3:0] col_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB_MAX  = 4'(DEBOUNCE_FRAMES);

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [15:0] r_div;
    logic [1:0]  r_row;
    logic [11:0] r_snap;      // rows 0..2; row 3 is taken live at frame end
    logic [15:0] r_prev;
    logic [15:0] r_deb;
    logic [3:0]  r_stable;
    logic [3:0]  r_key_code;
    logic        r_key_valid;
    logic        r_key_held;

    logic        w_sample;
    logic        w_frame_end;
    logic [3:0]  w_cols;
    logic [15:0] w_frame;
    logic [3:0]  w_stable_next;
    logic        w_accept;
    logic        w_single;
    logic [3:0]  w_index;

    assign w_sample    = (r_div == DIV_LAST);
    assign w_frame_end = w_sample && (r_row == 2'd3);
    assign w_cols      = ~r_sync2;
    assign w_frame     = {w_cols, r_snap};
    assign w_accept    = w_frame_end && (w_stable_next == DEB_MAX) && (w_frame != r_deb);
    assign w_single    = (w_frame != 16'd0) && ((w_frame & (w_frame - 16'd1)) == 16'd0);

    assign row_out   = ~(4'b0001 << r_row);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

    // Next consecutive-identical-frame count, saturating at DEBOUNCE_FRAMES
    always_comb begin
        w_stable_next = 4'd1;
        if (w_frame == r_prev) begin
            if (r_stable >= DEB_MAX)
                w_stable_next = DEB_MAX;
            else
                w_stable_next = r_stable + 4'd1;
        end
    end

    // Bit index of the pressed key; only meaningful when exactly one bit is set
    always_comb begin
        w_index = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_frame[i])
                w_index = 4'(i);
        end
    end

    // Two-flop synchronizer for the asynchronous column lines
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'd0;
            r_sync2 <= 4'd0;
        end else begin
            r_sync1 <= col_in;
            r_sync2 <= r_sync1;
        end
    end

    // Row divider and row pointer; latch each row's pressed columns at its last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= 16'd0;
            r_row  <= 2'd0;
            r_snap <= 12'd0;
        end else if (w_sample) begin
            r_div <= 16'd0;
            r_row <= r_row + 2'd1;
            case (r_row)
                2'd0:    r_snap[3:0]  <= w_cols;
                2'd1:    r_snap[7:4]  <= w_cols;
                2'd2:    r_snap[11:8] <= w_cols;
                default: ;
            endcase
        end else begin
            r_div <= r_div + 16'd1;
        end
    end

    // Frame-level debounce: count identical frames, accept a new matrix state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev   <= 16'd0;
            r_stable <= 4'd0;
            r_deb    <= 16'd0;
        end else if (w_frame_end) begin
            r_prev   <= w_frame;
            r_stable <= w_stable_next;
            if (w_accept)
                r_deb <= w_frame;
        end
    end

    // Key events: single press from idle reports, all-released clears held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_accept) begin
                if ((r_deb == 16'd0) && w_single) begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= w_index;
                    r_key_held  <= 1'b1;
                end else if (w_frame == 16'd0) begin
                    r_key_held <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a matrix model drives col_in from a pressed-key
// mask, a frame-level reference model predicts outputs every cycle, and
// directed scenarios pin the model with hand-computed literals.
module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DF    = 3;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_out;
    logic [3:0]  col_in;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] mask = 16'd0;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    int          m_e    = 0;
    int          m_cnt  = 0;
    logic [15:0] m_prev = 16'd0;
    logic [15:0] m_deb  = 16'd0;
    logic [3:0]  m_code = 4'd0;
    logic        m_valid = 1'b0;
    logic        m_held  = 1'b0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_out   (row_out),
        .col_in    (col_in),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Matrix: a pressed key pulls its column low while its row is driven low
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_out[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (mask[r*4+c])
                        col_in[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one snapshot per 16-cycle frame equal to the mask held that frame
    task automatic model_step();
        if (rst) begin
            m_e = 0; m_cnt = 0; m_prev = 16'd0; m_deb = 16'd0;
            m_code = 4'd0; m_valid = 1'b0; m_held = 1'b0;
        end else begin
            m_e++;
            m_valid = 1'b0;
            if (m_e % FRAME == 0) begin
                if (mask == m_prev)
                    m_cnt = (m_cnt + 1 > DF) ? DF : m_cnt + 1;
                else
                    m_cnt = 1;
                m_prev = mask;
                if (m_cnt == DF && mask != m_deb) begin
                    if (m_deb == 16'd0 && $countones(mask) == 1) begin
                        m_valid = 1'b1;
                        m_held  = 1'b1;
                        for (int i = 0; i < 16; i++)
                            if (mask[i]) m_code = 4'(i);
                    end else if (mask == 16'd0) begin
                        m_held = 1'b0;
                    end
                    m_deb = mask;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        chk("row_out",   {12'd0, row_out}, {12'd0, ~(4'b0001 << ((m_e / SD) % 4))});
        chk("key_valid", {15'd0, key_valid}, {15'd0, m_valid});
        chk("key_held",  {15'd0, key_held},  {15'd0, m_held});
        chk("key_code",  {12'd0, key_code},  {12'd0, m_code});
        if (key_valid) pulses++;
    end

    task automatic frames(input logic [15:0] m, input int n);
        mask = m;
        repeat (n * FRAME) @(negedge clk);
    endtask

    task automatic outs_lit(input string name, input logic v, input logic h, input logic [3:0] c);
        chk({name, "_valid"}, {15'd0, key_valid}, {15'd0, v});
        chk({name, "_held"},  {15'd0, key_held},  {15'd0, h});
        chk({name, "_code"},  {12'd0, key_code},  {12'd0, c});
    endtask

    logic [3:0] walk [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    int p0;

    initial begin
        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        chk("reset_row", {12'd0, row_out}, 16'h000E);
        outs_lit("reset", 1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("row_walk", {12'd0, row_out}, {12'd0, walk[k]});
            if (k < 4) repeat (SD) @(negedge clk);
        end

        // Clean press of key 9 (row 2, col 1) and release
        p0 = pulses;
        frames(16'h0200, 2);
        outs_lit("press9_early", 1'b0, 1'b0, 4'd0);
        frames(16'h0200, 1);
        outs_lit("press9", 1'b1, 1'b1, 4'd9);
        frames(16'h0000, 2);
        outs_lit("rel9_early", 1'b0, 1'b1, 4'd9);
        frames(16'h0000, 1);
        outs_lit("rel9", 1'b0, 1'b0, 4'd9);
        chk("press9_pulses", 16'(pulses - p0), 16'd1);

        // Bounce on key 5, then hold
        p0 = pulses;
        for (int k = 0; k < 6; k++)
            frames((k % 2 == 0) ? 16'h0020 : 16'h0000, 1);
        chk("bounce_pulses", 16'(pulses - p0), 16'd0);
        frames(16'h0020, 2);
        outs_lit("bounce_hold_early", 1'b0, 1'b0, 4'd9);
        frames(16'h0020, 1);
        outs_lit("bounce_hold", 1'b1, 1'b1, 4'd5);
        frames(16'h0000, 3);

        // Multi-key from idle is never reported
        p0 = pulses;
        frames(16'h8001, 4);
        outs_lit("multi", 1'b0, 1'b0, 4'd5);
        chk("multi_pulses", 16'(pulses - p0), 16'd0);
        frames(16'h0000, 3);
        frames(16'h0008, 3);
        outs_lit("key3", 1'b1, 1'b1, 4'd3);
        frames(16'h0000, 3);

        // Second key while holding
        frames(16'h0080, 3);
        outs_lit("key7", 1'b1, 1'b1, 4'd7);
        p0 = pulses;
        frames(16'h0180, 4);
        outs_lit("key7_plus8", 1'b0, 1'b1, 4'd7);
        chk("second_key_pulses", 16'(pulses - p0), 16'd0);
        frames(16'h0000, 2);
        outs_lit("rel78_early", 1'b0, 1'b1, 4'd7);
        frames(16'h0000, 1);
        outs_lit("rel78", 1'b0, 1'b0, 4'd7);

        // Reset in the middle of debouncing key 12
        frames(16'h1000, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_row", {12'd0, row_out}, 16'h000E);
        outs_lit("midreset", 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        frames(16'h1000, 2);
        outs_lit("key12_early", 1'b0, 1'b0, 4'd0);
        frames(16'h1000, 1);
        outs_lit("key12", 1'b1, 1'b1, 4'd12);
        frames(16'h0000, 3);

        // Randomized traffic, including resets at arbitrary points in a frame
        for (int it = 0; it < 60; it++) begin
            int kind;
            logic [15:0] m;
            kind = $urandom_range(0, 9);
            if (kind == 9) begin
                repeat ($urandom_range(1, FRAME - 1)) @(negedge clk);
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end else begin
                if (kind <= 2)
                    m = 16'd0;
                else if (kind <= 6)
                    m = 16'd1 << $urandom_range(0, 15);
                else
                    m = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
                frames(m, $urandom_range(1, 5));
            end
        end
        frames(16'h0000, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad and turns it into debounced key events for the digital clock. It is the input-side counterpart of the multiplexed tube display. Rows are strobed one at a time, just as the display strobes digit selects, and the column lines are read back. Its `key_valid`/`key_code` outputs feed the clock's set/adjust logic in the top level.

## Interface

- `SCAN_DIV`, default 50000: clock cycles each row is driven (1 ms at 50 MHz); legal range 4..65535.
- `DEBOUNCE_FRAMES`, default 5: consecutive identical full-matrix frames required to accept a new key state; legal range 2..15.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `row_out`  out  4  row drive, active-low; exactly one bit low at all times.
- `col_in`  in  4  column sense, active-low (external pull-ups), asynchronous to `clk`.
- `key_code`  out  4  code of the last accepted key, row*4 + col.
- `key_valid`  out  1  one-cycle pulse when a new single key press is accepted.
- `key_held`  out  1  high from the accepted press until the debounced matrix is all-released.

## Operation

- **Input synchronizer:** `col_in` passes through a 2-flop synchronizer before any use.
- **Row scan:**
  - Row counter `r` is 0..3; `row_out = ~(4'b0001 << r)`.
  - Divider counts 0..SCAN_DIV-1.
  - When the divider is at SCAN_DIV-1, the synchronized columns are sampled into `snap[r*4 +: 4]`, inverted so that 1 = pressed. The divider then wraps and `r` advances, with 3 wrapping to 0.
- **Frame end:** the sample cycle of row 3. On frame end:
  - If the assembled 16-bit `snap` equals `prev`, `stable_cnt` = min(`stable_cnt`+1, DEBOUNCE_FRAMES). Otherwise `stable_cnt` = 1.
  - `prev` <= `snap`.
- **Acceptance:** at frame end, if the new `stable_cnt` == DEBOUNCE_FRAMES and `snap` != `deb`, then `deb` <= `snap`. Call the old value `old_deb` and the new value `new_deb`.
- **Event rules**, evaluated on a `deb` update:
  - `old_deb`==0 and `new_deb` has exactly one bit set at index i: `key_valid` pulses, `key_code` <= i, `key_held` <= 1.
  - `new_deb`==0: `key_held` <= 0; no pulse.
  - Any other transition produces no pulse and leaves `key_code`/`key_held` unchanged. This covers multi-key from idle, adding a second key while holding, and releasing one of several keys.
- **Ghosting:** not resolved. A multi-bit `deb` is simply never reported as a key.
- **Reset values:**
  - Outputs: `row_out`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0.
  - Internal state: divider, `r`, `stable_cnt`, `snap`, `prev`, `deb` and the synchronizer flops all 0.
- **Mid-scan reset:** reset asserted mid-scan returns everything to these values on the next edge. Scanning restarts at row 0 with a fresh debounce history.

## Timing

- **Frame and row:** frame period = 4*SCAN_DIV cycles. A row is driven for SCAN_DIV-1 cycles before its sample, which absorbs the 2-cycle synchronizer and line settling.
- **`key_valid` latency:** `key_valid` is high for exactly one cycle, the cycle after the frame-end edge that updates `deb`. `key_code` becomes valid in that same cycle and holds afterwards.
- **Press latency:** a bounce-free press that is stable before a frame starts is accepted at the end of the DEBOUNCE_FRAMES-th frame. The pulse follows 1 cycle later, so the worst case is (DEBOUNCE_FRAMES+1) frames after the press.
- **Release latency:** `key_held` falls 1 cycle after the frame end on which the all-zero snapshot reaches DEBOUNCE_FRAMES consecutive frames.
- **Bounce:** any snapshot change resets the count to 1, so bounce shorter than DEBOUNCE_FRAMES frames never changes `deb`.
- **Counter saturation:** `stable_cnt` saturates at DEBOUNCE_FRAMES; a long steady state never re-triggers because `snap`==`deb`.
- **Event rate:** at most one `key_valid` per release/press cycle. Back-to-back presses need an intervening accepted all-released state.

## Test plan

Benches use SCAN_DIV=4 and DEBOUNCE_FRAMES=3 (frame = 16 cycles) and a behavioural matrix model that drives `col_in` low when the pressed key's row is low.

- **Reset:** hold `rst` 3 cycles. Expect `row_out`=1110, outputs 0. `row_out` then walks 1110→1101→1011→0111→1110 with 4 cycles per step.
- **Clean press and release:**
  - Press key row 2/col 1 at a frame start. Expect one `key_valid` pulse with `key_code`=9 and `key_held`=1 at frame-3 end + 1 cycle.
  - Release. Expect `key_held`=0 three frames later with no extra pulse.
- **Bounce:**
  - Toggle key 5 every frame for 6 frames, then hold it. Expect no pulse during the toggling.
  - Exactly one pulse, `key_code`=5, after 3 stable frames.
- **Multi-key:**
  - From idle press keys 0 and 15 together. Expect no pulse and `key_held`=0.
  - Release, then press key 3 alone. Expect a pulse with `key_code`=3.
- **Second key while holding:** hold key 7 (pulse, code 7), add key 8. Expect no pulse, `key_code` stays 7, `key_held` stays 1 until both are released.
- **Reset mid-debounce:** press key 12 and assert `rst` after 2 frames. Expect outputs 0 and a restart at row 0. The pulse for 12 arrives 3 full frames after reset release.
